// File: rtl/cpu_if_pkg.sv
// rtl/cpu_if_pkg.sv - shared types and constants for the instruction fetch prefetch queue
package cpu_if_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int ENTRY_W = ADDR_W + INST_W;

    localparam logic [ADDR_W-1:0] PC_INC = 32'd4;
    localparam logic [INST_W-1:0] NOP = 32'h0;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_DISCARD = 1'b1
    } fetch_state_t;

    // Occupancy counter must represent 0..DEPTH inclusive
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cpu_if_fifo.sv
// rtl/cpu_if_fifo.sv - prefetch queue storage holding {pc, inst} entries
module cpu_if_fifo
    import cpu_if_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = count_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clear,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic [CW-1:0]      count
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    assign head = mem[rd_ptr];

    // en low freezes everything, including reset and clear
    always_ff @(posedge clk) begin
        if (en) begin
            if (rst || clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= push_data;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/cpu_if_pfq.sv
// rtl/cpu_if_pfq.sv - instruction fetch unit with prefetch queue and branch/jump flush
module cpu_if_pfq
    import cpu_if_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_stall,
    input  logic              stall,
    input  logic              pc_b,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              pc_j,
    input  logic [ADDR_W-1:0] j_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] iin,
    output logic [ADDR_W-1:0] p_pc,
    output logic [INST_W-1:0] p_inst,
    output logic              p_valid
);

    localparam int CW = count_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  fpc_q, fpc_d;
    logic [ADDR_W-1:0]  daddr_q, daddr_d;
    logic [ADDR_W-1:0]  p_pc_d;
    logic [INST_W-1:0]  p_inst_d;
    logic               p_valid_d;

    logic               flush;
    logic [ADDR_W-1:0]  target;
    logic               ack;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [CW-1:0]      count;

    cpu_if_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .en        (!cpu_stall),
        .clear     (flush),
        .push      (push),
        .push_data ({fpc_q, iin}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        flush     = pc_b | pc_j;
        target    = pc_b ? b_addr : j_addr;
        imem_req  = (state_q == ST_DISCARD) || (count < DEPTH_C);
        imem_addr = (state_q == ST_DISCARD) ? daddr_q : fpc_q;
        ack       = imem_ack && imem_req;

        state_d = state_q;
        fpc_d   = fpc_q;
        daddr_d = daddr_q;
        push    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    fpc_d = target;
                    // The in-flight request cannot be withdrawn; park its address
                    if (imem_req && !ack) begin
                        state_d = ST_DISCARD;
                        daddr_d = fpc_q;
                    end
                end else if (ack) begin
                    push  = 1'b1;
                    fpc_d = fpc_q + PC_INC;
                end
            end
            ST_DISCARD: begin
                if (flush) begin
                    fpc_d = target;
                end
                if (ack) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        pop       = !flush && !stall && (count != '0);
        p_pc_d    = p_pc;
        p_inst_d  = p_inst;
        p_valid_d = p_valid;
        if (flush) begin
            p_pc_d    = '0;
            p_inst_d  = NOP;
            p_valid_d = 1'b0;
        end else if (!stall) begin
            if (count != '0) begin
                p_pc_d    = head[ENTRY_W-1:INST_W];
                p_inst_d  = head[INST_W-1:0];
                p_valid_d = 1'b1;
            end else begin
                p_pc_d    = '0;
                p_inst_d  = NOP;
                p_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!cpu_stall) begin
            if (rst) begin
                state_q <= ST_RUN;
                fpc_q   <= RESET_PC;
                daddr_q <= RESET_PC;
                p_pc    <= '0;
                p_inst  <= NOP;
                p_valid <= 1'b0;
            end else begin
                state_q <= state_d;
                fpc_q   <= fpc_d;
                daddr_q <= daddr_d;
                p_pc    <= p_pc_d;
                p_inst  <= p_inst_d;
                p_valid <= p_valid_d;
            end
        end
    end

endmodule

// File: tb/tb_cpu_if_pfq.sv
// tb/tb_cpu_if_pfq.sv - self-checking bench for cpu_if_pfq against a queue-based fetch model
module tb_cpu_if_pfq;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst, cpu_stall, stall, pc_b, pc_j, imem_ack;
    logic [31:0] b_addr, j_addr, iin;
    logic        imem_req, p_valid;
    logic [31:0] imem_addr, p_pc, p_inst;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    logic [63:0] mq[$];
    logic [31:0] m_fpc, m_old, m_p_pc, m_p_inst;
    bit          m_discard, m_p_valid;

    always #5 clk = ~clk;

    cpu_if_pfq #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_stall (cpu_stall),
        .stall     (stall),
        .pc_b      (pc_b),
        .b_addr    (b_addr),
        .pc_j      (pc_j),
        .j_addr    (j_addr),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .iin       (iin),
        .p_pc      (p_pc),
        .p_inst    (p_inst),
        .p_valid   (p_valid)
    );

    function automatic bit m_req();
        return m_discard || (mq.size() < DEPTH);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_discard ? m_old : m_fpc;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level view: a list of fetched words, a fetch pointer, and one pending-discard flag
    task automatic model_step();
        bit          fl, ack, req;
        logic [31:0] tgt;
        logic [63:0] e;
        if (cpu_stall) return;
        if (rst) begin
            mq.delete();
            m_fpc = RESET_PC; m_old = RESET_PC; m_discard = 0;
            m_p_pc = 0; m_p_inst = 0; m_p_valid = 0;
            return;
        end
        fl  = pc_b || pc_j;
        tgt = pc_b ? b_addr : j_addr;
        req = m_req();
        ack = imem_ack && req;
        if (fl) begin
            m_p_pc = 0; m_p_inst = 0; m_p_valid = 0;
        end else if (!stall) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_p_pc = e[63:32]; m_p_inst = e[31:0]; m_p_valid = 1;
            end else begin
                m_p_pc = 0; m_p_inst = 0; m_p_valid = 0;
            end
        end
        if (fl) begin
            mq.delete();
            if (m_discard) begin
                if (ack) m_discard = 0;
            end else if (req && !ack) begin
                m_discard = 1;
                m_old = m_fpc;
            end
            m_fpc = tgt;
        end else if (m_discard) begin
            if (ack) m_discard = 0;
        end else if (ack) begin
            mq.push_back({m_fpc, iin});
            m_fpc = m_fpc + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_req", imem_req, m_req());
            check("imem_addr", imem_addr, m_addr());
            check("p_valid", p_valid, m_p_valid);
            check("p_pc", p_pc, m_p_pc);
            check("p_inst", p_inst, m_p_inst);
        end
    end

    initial begin
        rst = 1; cpu_stall = 0; stall = 0; pc_b = 0; pc_j = 0; imem_ack = 0;
        b_addr = 0; j_addr = 0; iin = 0;
        tick();
        tick();
        rst = 0;
        chk_en = 1;
        check("rst_req", imem_req, 1);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", p_valid, 0);

        for (int k = 1; k <= 6; k++) begin
            imem_ack = 1; iin = m_addr() + 1;
            tick();
            if (k == 1) check("seq_first_bubble", p_valid, 0);
            if (k == 2) begin
                check("seq_first_valid", p_valid, 1);
                check("seq_first_pc", p_pc, 32'h0);
            end
        end
        check("seq_pc", p_pc, 32'd16);
        check("seq_inst", p_inst, 32'd17);

        stall = 1;
        for (int k = 0; k < 10; k++) begin
            imem_ack = m_req(); iin = m_addr() + 1;
            tick();
        end
        check("stall_req_drop", imem_req, 0);
        check("stall_hold_pc", p_pc, 32'd16);
        stall = 0; imem_ack = 0;
        for (int k = 0; k < 4; k++) tick();
        check("drain_pc", p_pc, 32'd32);
        check("drain_inst", p_inst, 32'd33);
        tick();
        check("drain_bubble", p_valid, 0);
        check("drain_next_addr", imem_addr, 32'd36);

        pc_j = 1; j_addr = 32'h10; imem_ack = 1; iin = $urandom;
        tick();
        pc_j = 0; imem_ack = 0;
        check("jmp_addr", imem_addr, 32'h10);
        tick();
        pc_b = 1; b_addr = 32'h100;
        tick();
        pc_b = 0;
        check("disc_addr_hold", imem_addr, 32'h10);
        check("disc_req", imem_req, 1);
        tick();
        check("disc_addr_hold2", imem_addr, 32'h10);
        imem_ack = 1; iin = 32'hDEAD_BEEF;
        tick();
        check("disc_next_addr", imem_addr, 32'h100);
        iin = m_addr() + 1;
        tick();
        check("br_no_valid_yet", p_valid, 0);
        iin = m_addr() + 1;
        tick();
        check("br_first_valid", p_valid, 1);
        check("br_first_pc", p_pc, 32'h100);

        pc_b = 1; b_addr = 32'h40; pc_j = 1; j_addr = 32'h80; stall = 1; imem_ack = 1; iin = $urandom;
        tick();
        pc_b = 0; pc_j = 0; stall = 0;
        check("bj_bubble", p_valid, 0);
        check("bj_addr", imem_addr, 32'h40);

        pc_j = 1; j_addr = 32'hFFFF_FFFC; imem_ack = 1;
        tick();
        pc_j = 0;
        check("wrap_addr_pre", imem_addr, 32'hFFFF_FFFC);
        iin = 32'h1234_5678;
        tick();
        imem_ack = 0;
        check("wrap_addr", imem_addr, 32'h0);

        cpu_stall = 1;
        for (int i = 0; i < 5; i++) begin
            imem_ack = (i % 2 == 0); iin = $urandom;
            pc_b = (i == 2); b_addr = 32'h500; rst = (i == 3);
            tick();
            check("frz_addr", imem_addr, 32'h0);
            check("frz_valid", p_valid, 0);
        end
        cpu_stall = 0; pc_b = 0; rst = 0; imem_ack = 0;
        tick();
        check("frz_pop_pc", p_pc, 32'hFFFF_FFFC);
        check("frz_pop_inst", p_inst, 32'h1234_5678);
        check("frz_addr_after", imem_addr, 32'h0);
        imem_ack = 1; iin = m_addr() + 1;
        tick();
        imem_ack = 0;
        check("frz_ack_addr", imem_addr, 32'h4);

        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            cpu_stall = ($urandom_range(0, 9) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            pc_b      = ($urandom_range(0, 19) == 0);
            pc_j      = ($urandom_range(0, 24) == 0);
            b_addr    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
            b_addr[1:0] = 2'b00;
            j_addr    = $urandom;
            j_addr[1:0] = 2'b00;
            imem_ack  = m_req() && ($urandom_range(0, 2) != 0);
            iin       = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_if_pfq.md
CPU_IF_PFQ -- requirements
Module: cpu_if_pfq

Interface
REQ-001 Parameter DEPTH, default 4, prefetch queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 Ports clk in 1 (sole clock) and rst in 1; reset is synchronous and active-high.
REQ-004 cpu_stall  in  1  global freeze; all state holds while high.
REQ-005 stall  in  1  decode hazard; hold the p_* outputs.
REQ-006 pc_b  in  1  branch taken; b_addr  in  32  branch target.
REQ-007 pc_j  in  1  jump; j_addr  in  32  jump target.
REQ-008 imem_req  out  1  fetch request, level, held until acknowledged.
REQ-009 imem_addr  out  32  fetch address, stable while imem_req is high.
REQ-010 imem_ack  in  1  fetch done; iin  in  32  instruction, valid with imem_ack.
REQ-011 p_pc  out  32, p_inst  out  32, p_valid  out  1  registered outputs to decode.

Function
REQ-012 flush = pc_b | pc_j; target = b_addr when pc_b, otherwise j_addr.
REQ-013 When cpu_stall=1: no register changes, imem_req and imem_addr hold, imem_ack ignored.
REQ-014 Fetch FSM states: RUN and DISCARD; at most one outstanding request.
REQ-015 RUN: imem_req=1 iff count<DEPTH; imem_addr=fpc; on imem_ack push {fpc,iin} and set fpc<=fpc+4.
REQ-016 RUN, flush with imem_req=1 and imem_ack=0: go to DISCARD; hold imem_req/imem_addr; fpc<=target.
REQ-017 DISCARD: imem_req=1 at the old address; on imem_ack drop iin, go to RUN; fpc unchanged.
REQ-018 Flush with imem_ack=1 in the same cycle: drop iin, fpc<=target, stay RUN.
REQ-019 Flush with no request outstanding: fpc<=target, stay RUN.
REQ-020 A second flush in DISCARD overwrites fpc with the newer target.
REQ-021 Flush clears the queue (count<=0) in the same cycle; any push in that cycle is dropped.
REQ-022 Output stage, first matching rule: flush -> p_pc=0, p_inst=0, p_valid=0.
REQ-023 Then stall -> hold p_*.
REQ-024 Then count>0 -> pop the head into p_pc/p_inst and set p_valid=1.
REQ-025 Otherwise output a bubble: p_pc=0, p_inst=0, p_valid=0.
REQ-026 There is no bypass; iin acknowledged at edge N appears on p_inst after edge N+1 at the earliest.
REQ-027 Simultaneous push and pop leave count unchanged; pointers wrap modulo DEPTH.
REQ-028 count width is clog2(DEPTH)+1; count never exceeds DEPTH, because imem_req is gated by count<DEPTH.
REQ-029 fpc+4 wraps modulo 2^32 without error.

Reset
REQ-030 Reset applies only with rst=1 at a clk edge when cpu_stall=0.
REQ-031 Reset values: fpc=RESET_PC, FSM=RUN, count=0, pointers=0, p_pc=0, p_inst=0, p_valid=0.
REQ-032 rst during DISCARD or with a request outstanding abandons that request; any late imem_ack is ignored only while rst=1.
REQ-033 After rst falls, imem_req=1 with imem_addr=RESET_PC in the first cycle.

Structure
REQ-034 Shared package cpu_if_pkg holds the FSM state encoding, NOP value 32'h0, instruction and address widths, and the PC increment (4).
REQ-035 The queue is one sub-module, cpu_if_fifo (DEPTH x 64 bits), with push/pop/clear/count; FSM and output stage sit in cpu_if_pfq.

Verification
REQ-036 Reset with RESET_PC=0 and single-cycle ack of iin=addr+1 -> p_pc sequence 0,4,8,... with p_inst=p_pc+1 and p_valid=1 from the third cycle.
REQ-037 DEPTH=4, ack every cycle, stall held 10 cycles -> imem_req drops when count=4; p_* hold; no entry lost or duplicated after release.
REQ-038 Request at 0x10 outstanding 3 cycles, pc_b=1 with b_addr=0x100 in cycle 1 -> imem_addr stays 0x10 until ack, that data is discarded, next request is 0x100, and the first p_valid shows p_pc=0x100.
REQ-039 pc_b=1 (b_addr=0x40) with pc_j=1 (j_addr=0x80) and stall=1 in the same cycle -> bubble output, fetch resumes at 0x40.
REQ-040 cpu_stall=1 for 5 cycles with imem_ack pulsed -> no state change; imem_addr stable; the fetch completes only on an ack after cpu_stall falls.
REQ-041 fpc=0xFFFFFFFC with an ack -> next imem_addr=0x00000000.
